// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, defaults and types for the instruction-fetch front end.
package if_fetch_unit_pkg;

    localparam int unsigned InstAddrBus    = 32;
    localparam int unsigned InstBus        = 32;
    localparam int unsigned FetchFifoDepth = 2;

    localparam logic [InstAddrBus-1:0] ResetPc = 32'h0000_0000;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    typedef enum logic {StIdle, StRun} fetch_state_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned fifo_cnt_width(int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of the ROM read port, pipeline control inputs and the decode handshake.
interface if_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic              stall;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;

    modport master (
        output rom_ce, rom_addr, id_valid, id_pc, id_inst,
        input  rom_inst, stall, branch_flag, branch_target, id_ready
    );

    modport slave (
        input  rom_ce, rom_addr, id_valid, id_pc, id_inst,
        output rom_inst, stall, branch_flag, branch_target, id_ready
    );
endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO holding {pc, inst} pairs; flush empties it in one cycle.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = fifo_cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok)  rptr_d = rptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: PC register, chip-enable sequencing, fetch/branch control and fetch buffer.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned     ADDR_W     = InstAddrBus,
    parameter int unsigned     INST_W     = InstBus,
    parameter logic [ADDR_W-1:0] RESET_PC = ResetPc,
    parameter int unsigned     FIFO_DEPTH = FetchFifoDepth
) (
    input logic             clk,
    input logic             rst,
    if_fetch_unit_if.master bus
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce;
    logic              fifo_full, fifo_empty;
    logic              pop, fetch;
    logic [ADDR_W+INST_W-1:0] head;
    logic              unused_tgt_lsb;

    assign unused_tgt_lsb = ^bus.branch_target[1:0];

    assign ce    = (state_q == StRun) ? ChipEnable : ChipDisable;
    assign pop   = !fifo_empty && bus.id_ready;
    assign fetch = ce && !bus.stall && !bus.branch_flag && (!fifo_full || pop);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Branch wins over stall and fetch, and is honoured even before ce rises.
    always_comb begin
        pc_d = pc_q;
        if (bus.branch_flag) begin
            pc_d = {bus.branch_target[ADDR_W-1:2], 2'b00};
        end else if (fetch) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fetch),
        .wdata_i ({pc_q, bus.rom_inst}),
        .pop_i   (pop),
        .flush_i (bus.branch_flag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    assign bus.rom_ce   = ce;
    assign bus.rom_addr = pc_q;
    assign bus.id_valid = !fifo_empty;
    assign bus.id_pc    = head[ADDR_W+INST_W-1:INST_W];
    assign bus.id_inst  = head[INST_W-1:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit with a ROM returning inst = addr >> 2.
module tb_if_fetch_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    if_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // mem[i] = i for every word address
    assign bus.rom_inst = {2'b00, bus.rom_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        ce;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vec [23];

    function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic r, logic c,
                                logic [31:0] a, logic v, logic [31:0] p, logic [31:0] i);
        vec_t x;
        x = '{stall: s, br: b, tgt: t, rdy: r, ce: c, addr: a, v: v, pc: p, inst: i};
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, " rom_ce"},   {31'd0, bus.rom_ce},   {31'd0, e.ce});
        chk({tag, " rom_addr"}, bus.rom_addr,          e.addr);
        chk({tag, " id_valid"}, {31'd0, bus.id_valid}, {31'd0, e.v});
        chk({tag, " id_pc"},    bus.id_pc,             e.pc);
        chk({tag, " id_inst"},  bus.id_inst,           e.inst);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // stall br tgt rdy | ce addr valid pc inst
        vec[0]  = mk(0, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0,   32'h0);
        vec[1]  = mk(0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0,   32'h0);
        vec[2]  = mk(0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h4,   32'h1);
        vec[3]  = mk(0, 0, 32'h0,   0, 1, 32'hC,   1, 32'h4,   32'h1);
        vec[4]  = mk(0, 0, 32'h0,   0, 1, 32'hC,   1, 32'h4,   32'h1);
        vec[5]  = mk(0, 0, 32'h0,   0, 1, 32'hC,   1, 32'h4,   32'h1);
        vec[6]  = mk(0, 0, 32'h0,   0, 1, 32'hC,   1, 32'h4,   32'h1);
        vec[7]  = mk(0, 0, 32'h0,   0, 1, 32'hC,   1, 32'h4,   32'h1);
        vec[8]  = mk(0, 0, 32'h0,   1, 1, 32'h10,  1, 32'h8,   32'h2);
        vec[9]  = mk(0, 0, 32'h0,   1, 1, 32'h14,  1, 32'hC,   32'h3);
        vec[10] = mk(1, 0, 32'h0,   1, 1, 32'h14,  1, 32'h10,  32'h4);
        vec[11] = mk(1, 0, 32'h0,   1, 1, 32'h14,  0, 32'h0,   32'h0);
        vec[12] = mk(1, 0, 32'h0,   1, 1, 32'h14,  0, 32'h0,   32'h0);
        vec[13] = mk(0, 0, 32'h0,   1, 1, 32'h18,  1, 32'h14,  32'h5);
        vec[14] = mk(0, 0, 32'h0,   0, 1, 32'h1C,  1, 32'h14,  32'h5);
        vec[15] = mk(0, 1, 32'h203, 0, 1, 32'h200, 0, 32'h0,   32'h0);
        vec[16] = mk(0, 0, 32'h0,   0, 1, 32'h204, 1, 32'h200, 32'h80);
        vec[17] = mk(1, 1, 32'h400, 1, 1, 32'h400, 0, 32'h0,   32'h0);
        vec[18] = mk(1, 0, 32'h0,   1, 1, 32'h400, 0, 32'h0,   32'h0);
        vec[19] = mk(0, 1, 32'hFFFF_FFF8, 1, 1, 32'hFFFF_FFF8, 0, 32'h0, 32'h0);
        vec[20] = mk(0, 0, 32'h0,   1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'h3FFF_FFFE);
        vec[21] = mk(0, 0, 32'h0,   1, 1, 32'h0,   1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        vec[22] = mk(0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0,   32'h0);

        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_flag   = 1'b0;
        bus.branch_target = 32'h0;
        bus.id_ready      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("reset", mk(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0));

        for (int i = 0; i < 23; i++) begin
            bus.stall         = vec[i].stall;
            bus.branch_flag   = vec[i].br;
            bus.branch_target = vec[i].tgt;
            bus.id_ready      = vec[i].rdy;
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), vec[i]);
        end

        // Asynchronous reset mid-cycle with an entry buffered.
        bus.stall       = 1'b0;
        bus.branch_flag = 1'b0;
        bus.id_ready    = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        chk_all("async_rst", mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0));

        // Branch while ce is still low: target latched, fetch starts there.
        @(posedge clk);
        #1;
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h0000_0105;
        bus.id_ready      = 1'b0;
        rst               = 1'b0;
        @(posedge clk);
        #1;
        chk_all("idle_br", mk(0, 0, 32'h0, 0, 1, 32'h104, 0, 32'h0, 32'h0));
        bus.branch_flag = 1'b0;
        @(posedge clk);
        #1;
        chk_all("idle_br_fetch", mk(0, 0, 32'h0, 0, 1, 32'h108, 1, 32'h104, 32'h41));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
